doodle_gait_sequencer: RTL

Upstream stage of the doodle leg servo path. It merges the speed prescaler, the gait address counter, the start-up calibration timer and line-follow steering into one registered controller. Outputs:
- the gait ROM address, consumed by the right, left and centre leg ROMs;
- per-leg movement enables, consumed by each servopwm `enable_mov` input.

IR inputs arrive already debounced. Steering decisions are taken only at gait-cycle boundaries, so no leg changes mode mid-stride.

---
 rtl/doodle_gait_sequencer_if.sv | 34 +++
 rtl/doodle_gait_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/doodle_gait_sequencer_if.sv
// Sensor inputs and leg-drive outputs of the doodle gait sequencer.
// The master modport is the sequencer; the slave side drives sensors and consumes outputs.
interface doodle_gait_sequencer_if;
   logic       l_ir;
   logic       r_ir;
   logic [7:0] addr;
   logic       en_l;
   logic       en_r;
   logic       en_c;
   logic       step;
   logic [2:0] state;

   modport master (
      input  l_ir,
      input  r_ir,
      output addr,
      output en_l,
      output en_r,
      output en_c,
      output step,
      output state
   );

   modport slave (
      output l_ir,
      output r_ir,
      input  addr,
      input  en_l,
      input  en_r,
      input  en_c,
      input  step,
      input  state
   );
endinterface

// File: rtl/doodle_gait_sequencer.sv
// Gait controller: step prescaler, gait ROM address counter, start-up calibration hold
// and line-follow steering decided only at gait-cycle boundaries.
module doodle_gait_sequencer #(
   parameter int unsigned STEP_DIV    = 800000,
   parameter int unsigned INIT_TICKS  = 80000000,
   parameter int unsigned GAIT_LEN    = 256,
   parameter int unsigned LOST_CYCLES = 4
) (
   input logic                     clk,
   input logic                     rst,
   doodle_gait_sequencer_if.master gait
);

   localparam int unsigned PrescW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned InitW  = (INIT_TICKS > 1) ? $clog2(INIT_TICKS) : 1;
   localparam int unsigned LostW  = $clog2(LOST_CYCLES + 1);

   localparam logic [PrescW-1:0] PrescLast = PrescW'(STEP_DIV - 1);
   localparam logic [InitW-1:0]  InitLast  = InitW'(INIT_TICKS - 1);
   localparam logic [LostW-1:0]  LostLimit = LostW'(LOST_CYCLES);
   localparam logic [7:0]        AddrLast  = 8'(GAIT_LEN - 1);

   typedef enum logic [2:0] {
      StInit  = 3'd0,
      StWalk  = 3'd1,
      StTurnL = 3'd2,
      StTurnR = 3'd3,
      StLost  = 3'd4,
      StStop  = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [PrescW-1:0] presc_q, presc_d;
   logic [InitW-1:0]  init_q, init_d;
   logic [LostW-1:0]  lost_q, lost_d;
   logic [7:0]        addr_q, addr_d;
   logic              step_q, step_d;
   logic              en_l_q, en_l_d;
   logic              en_r_q, en_r_d;
   logic              en_c_q, en_c_d;

   logic              step_tick;
   logic              addr_wrap;
   logic [7:0]        addr_inc;
   logic [LostW-1:0]  lost_inc;

   // Prescaler free-runs in every state; the tick lines up with the registered step pulse.
   always_comb begin
      step_tick = (presc_q == PrescLast);
      presc_d   = step_tick ? '0 : presc_q + PrescW'(1);
      step_d    = step_tick;
      addr_wrap = (addr_q == AddrLast);
      addr_inc  = addr_wrap ? 8'd0 : addr_q + 8'd1;
      lost_inc  = lost_q + LostW'(1);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      init_d  = init_q;
      lost_d  = lost_q;

      unique case (state_q)
         StInit: begin
            if (init_q == InitLast) begin
               state_d = StWalk;
            end else begin
               init_d = init_q + InitW'(1);
            end
         end

         StWalk, StTurnL, StTurnR, StLost: begin
            if (step_tick) begin
               addr_d = addr_inc;
               // Steering only changes at the wrap so a stride is never cut short.
               if (addr_wrap) begin
                  unique case ({gait.l_ir, gait.r_ir})
                     2'b11: begin
                        state_d = StWalk;
                        lost_d  = '0;
                     end
                     2'b01: begin
                        state_d = StTurnL;
                        lost_d  = '0;
                     end
                     2'b10: begin
                        state_d = StTurnR;
                        lost_d  = '0;
                     end
                     2'b00: begin
                        lost_d  = lost_inc;
                        state_d = (lost_inc >= LostLimit) ? StStop : StLost;
                     end
                  endcase
               end
            end
         end

         StStop: begin
            if (step_tick && (gait.l_ir || gait.r_ir)) begin
               state_d = StWalk;
               lost_d  = '0;
            end
         end

         default: state_d = StInit;
      endcase
   end

   // Enables follow the next state so they switch on the same edge as state and addr.
   always_comb begin
      en_l_d = 1'b0;
      en_r_d = 1'b0;
      en_c_d = 1'b0;
      unique case (state_d)
         StWalk, StLost: begin
            en_l_d = 1'b1;
            en_r_d = 1'b1;
            en_c_d = 1'b1;
         end
         StTurnL: begin
            en_r_d = 1'b1;
            en_c_d = 1'b1;
         end
         StTurnR: begin
            en_l_d = 1'b1;
            en_c_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StInit;
         presc_q <= '0;
         init_q  <= '0;
         lost_q  <= '0;
         addr_q  <= 8'd0;
         step_q  <= 1'b0;
         en_l_q  <= 1'b0;
         en_r_q  <= 1'b0;
         en_c_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         init_q  <= init_d;
         lost_q  <= lost_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         en_l_q  <= en_l_d;
         en_r_q  <= en_r_d;
         en_c_q  <= en_c_d;
      end
   end

   assign gait.addr  = addr_q;
   assign gait.state = state_q;
   assign gait.step  = step_q;
   assign gait.en_l  = en_l_q;
   assign gait.en_r  = en_r_q;
   assign gait.en_c  = en_c_q;

endmodule
